// File: rtl/spi_word_rx.sv
// SPI mode-0 slave word receiver, fully oversampled in the clk50M domain.
// Receives WIDTH-bit frames on MOSI, replies with tx_word on MISO, flags bad bit counts.
module spi_word_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk50M,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             mosi,
  input  logic             cs_n,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_word,
  output logic [WIDTH-1:0] byte_data_received,
  output logic             byte_received,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // ---------------- pin synchronizers and edge events ----------------
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d, mosi_prev_q, mosi_prev_d;
  logic sck_rise_q, sck_rise_d, sck_fall_q, sck_fall_d;
  logic cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
  logic armed_q, armed_d;
  logic sck_s, mosi_s, cs_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // flush_q marks when cs_s reflects the pin rather than its reset value; a frame
  // already in progress at reset release is ignored until cs_n is seen high.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    mosi_prev_d = mosi_s;
    sck_rise_d  = sck_s & ~sck_prev_q;
    sck_fall_d  = ~sck_s & sck_prev_q;
    cs_fall_d   = armed_q & cs_prev_q & ~cs_s;
    cs_rise_d   = ~cs_prev_q & cs_s;
    armed_d     = armed_q | (flush_q[SYNC_STAGES-1] & cs_s);
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      flush_q     <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      mosi_prev_q <= 1'b0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      flush_q     <= flush_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      mosi_prev_q <= mosi_prev_d;
      sck_rise_q  <= sck_rise_d;
      sck_fall_q  <= sck_fall_d;
      cs_fall_q   <= cs_fall_d;
      cs_rise_q   <= cs_rise_d;
      armed_q     <= armed_d;
    end
  end

  // ---------------- frame FSM and datapath ----------------
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, data_q, data_d;
  logic             miso_q, miso_d, rcv_q, rcv_d, err_q, err_d, pend_q, pend_d;
  logic             start;

  // A frame start seen during DONE is held one cycle so it is not lost.
  assign start = cs_fall_q | pend_q;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cs_rise_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    rx_d   = rx_q;
    tx_d   = tx_q;
    data_d = data_q;
    miso_d = miso_q;
    rcv_d  = 1'b0;
    err_d  = 1'b0;
    pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          tx_d   = tx_word;
          miso_d = tx_word[WIDTH-1];
        end
      end
      SHIFT: begin
        // Frame end wins over a coincident SCK edge.
        if (!cs_rise_q) begin
          if (sck_rise_q) begin
            rx_d = {rx_q[WIDTH-2:0], mosi_prev_q};
            if (cnt_q != CW'(WIDTH + 1)) cnt_d = cnt_q + CW'(1);
          end
          if (sck_fall_q) begin
            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
            miso_d = tx_q[WIDTH-2];
          end
        end
      end
      DONE: begin
        pend_d = cs_fall_q;
        if (cnt_q == CW'(WIDTH)) begin
          data_d = rx_q;
          rcv_d  = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      data_q <= '0;
      miso_q <= 1'b0;
      rcv_q  <= 1'b0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      data_q <= data_d;
      miso_q <= miso_d;
      rcv_q  <= rcv_d;
      err_q  <= err_d;
      pend_q <= pend_d;
    end
  end

  assign miso               = miso_q;
  assign miso_oe            = ~cs_s;
  assign byte_data_received = data_q;
  assign byte_received      = rcv_q;
  assign frame_err          = err_q;

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx: valid/short/long frames, reply path, back-to-back,
// reset abort and the cs/sck edge collision.
module tb_spi_word_rx;
  logic        clk50M = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sck    = 1'b0;
  logic        mosi   = 1'b0;
  logic        cs_n   = 1'b1;
  logic [15:0] tx_word = '0;
  logic        miso, miso_oe, byte_received, frame_err;
  logic [15:0] byte_data_received;

  int total = 0;
  int bad   = 0;

  // strobe monitor, sampled on the inactive edge
  int          rcv_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [15:0] rcv_log[$];

  spi_word_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk50M(clk50M), .rst_n(rst_n), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .tx_word(tx_word),
    .byte_data_received(byte_data_received), .byte_received(byte_received),
    .frame_err(frame_err)
  );

  always #10 clk50M = ~clk50M;

  always @(negedge clk50M) begin
    if (byte_received) begin
      rcv_cnt++;
      rcv_log.push_back(byte_data_received);
    end
    if (frame_err) err_cnt++;
    if (byte_received && frame_err) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  // Drives nbits of word MSB first at 5 MHz; leaves cs_n high on return.
  // collide raises cs_n together with the last sck rise.
  task automatic send_frame(input logic [31:0] word, input int nbits, input bit collide,
                            output logic [31:0] miso_word, output bit oe_ok);
    miso_word = '0;
    oe_ok = 1'b1;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[nbits-1-i];
      tick(5);
      miso_word = {miso_word[30:0], miso};
      oe_ok = oe_ok & miso_oe;
      sck = 1'b1;
      if (collide && i == nbits - 1) cs_n = 1'b1;
      tick(5);
      sck = 1'b0;
    end
    tick(5);
    cs_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++;
    if (byte_data_received !== 16'h0000 || byte_received !== 1'b0 || frame_err !== 1'b0 ||
        miso !== 1'b0 || miso_oe !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: data=%h rcv=%b err=%b miso=%b oe=%b, want all 0",
               byte_data_received, byte_received, frame_err, miso, miso_oe);
    end
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_valid();
    logic [31:0] mw;
    bit          oe;
    int          first = -1, highs = 0, errs = 0;
    send_frame(32'h0528, 16, 1'b0, mw, oe);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk50M); #1;
      if (byte_received) begin
        highs++;
        if (first < 0) first = c;
      end
      if (frame_err) errs++;
    end
    total++;
    if (byte_data_received !== 16'h0528) begin
      bad++; $display("FAIL valid_data: got %h want 0528", byte_data_received);
    end
    total++;
    if (first !== 5) begin
      bad++; $display("FAIL valid_latency: got %0d want 5", first);
    end
    total++;
    if (highs !== 1) begin
      bad++; $display("FAIL valid_width: got %0d want 1", highs);
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL valid_no_err: got %0d want 0", errs);
    end
    tick(4);
  endtask

  task automatic test_bad_lengths();
    logic [31:0] mw;
    bit          oe;
    int          nb[3] = '{15, 17, 0};
    for (int k = 0; k < 3; k++) begin
      int e0 = err_cnt, r0 = rcv_cnt;
      send_frame(32'h1FFFF, nb[k], 1'b0, mw, oe);
      tick(10);
      total++;
      if (err_cnt - e0 !== 1 || rcv_cnt - r0 !== 0) begin
        bad++;
        $display("FAIL bad_len_%0d: err pulses %0d rcv pulses %0d, want 1 and 0",
                 nb[k], err_cnt - e0, rcv_cnt - r0);
      end
      total++;
      if (byte_data_received !== 16'h0528) begin
        bad++; $display("FAIL bad_len_hold_%0d: got %h want 0528", nb[k], byte_data_received);
      end
    end
  endtask

  task automatic test_reply();
    logic [31:0] mw;
    bit          oe;
    tx_word = 16'hA55A;
    tick(2);
    total++;
    if (miso_oe !== 1'b0) begin
      bad++; $display("FAIL reply_oe_before: got %b want 0", miso_oe);
    end
    send_frame(32'h0000, 16, 1'b0, mw, oe);
    tick(10);
    total++;
    if (mw[15:0] !== 16'hA55A) begin
      bad++; $display("FAIL reply_miso: got %h want a55a", mw[15:0]);
    end
    total++;
    if (oe !== 1'b1) begin
      bad++; $display("FAIL reply_oe_during: got %b want 1", oe);
    end
    total++;
    if (miso_oe !== 1'b0) begin
      bad++; $display("FAIL reply_oe_after: got %b want 0", miso_oe);
    end
    total++;
    if (byte_data_received !== 16'h0000) begin
      bad++; $display("FAIL reply_rx: got %h want 0000", byte_data_received);
    end
    tx_word = 16'h0000;
  endtask

  task automatic test_back_to_back();
    logic [31:0] mw;
    bit          oe;
    int          r0 = rcv_cnt, e0 = err_cnt;
    rcv_log.delete();
    send_frame(32'h0501, 16, 1'b0, mw, oe);
    tick(4);
    send_frame(32'h05FF, 16, 1'b0, mw, oe);
    tick(10);
    total++;
    if (rcv_cnt - r0 !== 2 || err_cnt - e0 !== 0) begin
      bad++; $display("FAIL b2b_counts: rcv %0d err %0d, want 2 and 0", rcv_cnt - r0, err_cnt - e0);
    end
    total++;
    if (rcv_log.size() != 2 || rcv_log[0] !== 16'h0501 || rcv_log[1] !== 16'h05FF) begin
      bad++;
      $display("FAIL b2b_data: got %0d words first %h last %h, want 0501 then 05ff",
               rcv_log.size(), (rcv_log.size() > 0) ? rcv_log[0] : 16'hxxxx,
               (rcv_log.size() > 1) ? rcv_log[1] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] mw;
    bit          oe;
    int          r0, e0;
    cs_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      tick(5); sck = 1'b1; tick(5); sck = 1'b0;
    end
    r0 = rcv_cnt; e0 = err_cnt;
    rst_n = 1'b0;
    tick(2);
    total++;
    if (byte_data_received !== 16'h0000 || byte_received !== 1'b0 || frame_err !== 1'b0 ||
        miso !== 1'b0 || miso_oe !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: data=%h rcv=%b err=%b miso=%b oe=%b, want all 0",
               byte_data_received, byte_received, frame_err, miso, miso_oe);
    end
    // release with cs_n still low: rest of this frame must be ignored
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mosi = 1'b1;
      tick(5); sck = 1'b1; tick(5); sck = 1'b0;
    end
    tick(5);
    cs_n = 1'b1;
    tick(10);
    total++;
    if (rcv_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin
      bad++; $display("FAIL midrst_abort: rcv %0d err %0d, want 0 and 0", rcv_cnt - r0, err_cnt - e0);
    end
    send_frame(32'h0A0B, 16, 1'b0, mw, oe);
    tick(10);
    total++;
    if (rcv_cnt - r0 !== 1 || byte_data_received !== 16'h0A0B) begin
      bad++;
      $display("FAIL midrst_next: rcv %0d data %h, want 1 and 0a0b", rcv_cnt - r0, byte_data_received);
    end
  endtask

  task automatic test_collision();
    logic [31:0] mw;
    bit          oe;
    int          r0 = rcv_cnt, e0 = err_cnt;
    send_frame(32'h1234, 16, 1'b1, mw, oe);
    tick(10);
    total++;
    if (err_cnt - e0 !== 1 || rcv_cnt - r0 !== 0) begin
      bad++; $display("FAIL collision: err %0d rcv %0d, want 1 and 0", err_cnt - e0, rcv_cnt - r0);
    end
    total++;
    if (byte_data_received !== 16'h0A0B) begin
      bad++; $display("FAIL collision_hold: got %h want 0a0b", byte_data_received);
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_bad_lengths();
    test_reply();
    test_back_to_back();
    test_reset_mid_frame();
    test_collision();
    total++;
    if (both_cnt !== 0) begin
      bad++; $display("FAIL strobes_exclusive: got %0d overlaps want 0", both_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_word_rx.md
# spi_word_rx

SPI slave front end that receives 16-bit command words from the host controller and presents them to the valve positioner stages as `byte_data_received` plus a one-cycle `byte_received` strobe. It runs entirely in the `clk50M` domain: the SPI pins are oversampled through synchronizers, so no SCK-clocked logic exists. It also shifts a 16-bit reply word back to the host on MISO and flags malformed frames.

## Interface
- `WIDTH`, 16: frame length in bits. Downstream consumers require 16; upper byte is the packet code, lower byte is the payload.
- `SYNC_STAGES`, 2: synchronizer depth on `sck`, `mosi` and `cs_n`. Legal value is 2 or more.
- `clk50M` input, 1 bit: system clock, 50 MHz.
- `rst_n` input, 1 bit: asynchronous, active-low reset. Deassertion is synchronous to `clk50M`.
- `sck` input, 1 bit: SPI clock, mode 0 (CPOL=0, CPHA=0). Asynchronous to `clk50M`.
- `mosi` input, 1 bit: serial data in, MSB first.
- `cs_n` input, 1 bit: chip select, active low, framing.
- `miso` output, 1 bit: serial reply data, MSB first.
- `miso_oe` output, 1 bit: MISO output enable. High while the synchronized `cs_n` is low.
- `tx_word` input, WIDTH bits: reply word, sampled at frame start.
- `byte_data_received` output, WIDTH bits: last valid received word. Held until the next valid frame.
- `byte_received` output, 1 bit: one-cycle strobe marking a new valid word.
- `frame_err` output, 1 bit: one-cycle strobe marking a frame that ended with a bit count other than WIDTH.

## Operation
- Synchronize `sck`, `mosi` and `cs_n` through `SYNC_STAGES` flops each. Keep one extra registered copy of `sck` and `cs_n` for edge detection.
- Derived events, each a single-cycle pulse:
  - `sck_rise` and `sck_fall` from the synchronized `sck`.
  - `cs_fall` (frame start) and `cs_rise` (frame end) from the synchronized `cs_n`.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Clear the bit counter.
  - On `cs_fall`: load `tx_word` into the TX shift register, drive `miso = tx_word[WIDTH-1]`, go to SHIFT.
- SHIFT:
  - On `sck_rise`: shift the synchronized `mosi` into the RX shift register LSB, with earlier bits moving toward the MSB. Increment the bit counter. The counter is `$clog2(WIDTH)+1` bits wide and saturates at WIDTH+1; it never wraps.
  - On `sck_fall`: shift the TX register left and drive its new MSB onto `miso`. After WIDTH bits, `miso` holds 0.
  - On `cs_rise`: go to DONE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - Bit count == WIDTH: copy the RX register to `byte_data_received` and pulse `byte_received`.
  - Any other count, including 0: pulse `frame_err`. `byte_data_received` is unchanged.
- Simultaneous events:
  - `cs_rise` in the same cycle as `sck_rise` or `sck_fall`: the SCK edge is ignored and the frame ends.
  - `cs_fall` while in DONE: taken in the following IDLE cycle. No edges are lost, because `cs_n` high time is at least 4 `clk50M` cycles.
- `rst_n` low at any time, including mid-frame: all state returns to reset values and the partial frame is discarded with no strobe. After release, the block waits in IDLE for the next `cs_fall`. If `cs_n` is already low at release, that frame is ignored until `cs_n` goes high and falls again.
- Reset values:
  - `byte_data_received` = 0, `byte_received` = 0, `frame_err` = 0.
  - `miso` = 0, `miso_oe` = 0.
  - State = IDLE, counter = 0, shift registers = 0, synchronizer flops = 1 for `cs_n` and 0 for `sck`/`mosi`.

## Timing
- Pin to event latency: `SYNC_STAGES`+1 cycles (3 cycles at default).
- `byte_received` rises 2 cycles after `cs_rise` is detected (the DONE cycle plus the output register). That is 5 `clk50M` cycles after the `cs_n` pin rises at default settings, and it stays high for exactly 1 cycle.
- `frame_err` has the same timing as `byte_received`. The two strobes are never high together.
- Host constraints:
  - SCK high and low phases each at least 4 `clk50M` cycles, i.e. SCK ≤ 6.25 MHz.
  - At least 4 cycles from `cs_n` falling to the first SCK rise.
  - At least 4 cycles from the last SCK fall to `cs_n` rising.
- MISO changes `SYNC_STAGES`+2 cycles after an SCK pin falling edge. This is within the half period under the constraints above.
- Back-to-back frames are fully supported; no minimum idle beyond the `cs_n` high time.

## Test plan
- Valid frame: 16 bits 0x0528 at 5 MHz -> `byte_data_received` = 0x0528 and `byte_received` high for 1 cycle, 5 cycles after `cs_n` rises. `frame_err` stays 0.
- Short frame: 15 bits, then `cs_n` high -> `frame_err` pulses for 1 cycle and `byte_data_received` keeps its previous value. Repeat with 17 bits and with 0 bits: `frame_err` pulses each time.
- Reply path: `tx_word` = 0xA55A before `cs_fall`, host sends 0x0000 -> MISO bits sampled on SCK rises read 0xA55A. `miso_oe` is high only during the frame.
- Back-to-back: 0x0501 then 0x05FF with 4-cycle `cs_n` gaps -> two strobes with data 0x0501 then 0x05FF, and no `frame_err`.
- Reset mid-frame: `rst_n` low after 8 bits, released, then a full 0x0A0B frame -> no strobe for the aborted frame, then `byte_received` with 0x0A0B. All outputs read 0 during reset.
- Edge collision: `cs_n` rises in the same synchronized cycle as the 16th `sck_rise` -> counted as 15 bits and `frame_err` pulses.
